disp_user_ctrl: RTL and testbench

//  Upstream configuration stage for the display controller: debounces push buttons and holds
//  the live display settings (position, char size, colours, flash clock) driving its config inputs.

---
 rtl/disp_user_ctrl_if.sv | 34 +++
 rtl/disp_user_ctrl.sv | 145 ++++++++++++++
 tb/tb_disp_user_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/disp_user_ctrl_if.sv
// Button and settings bundle between the user-control stage and the display controller.
// Signal direction prefixes (i_/o_) are taken from the control stage's point of view.
interface disp_user_ctrl_if;
    logic       i_btn_up;
    logic       i_btn_down;
    logic       i_btn_left;
    logic       i_btn_right;
    logic       i_btn_size_up;
    logic       i_btn_size_dn;
    logic       i_btn_color;
    logic       i_frame_start;
    logic [9:0] o_up_offset;
    logic [2:0] o_down_offset;
    logic [2:0] o_left_offset;
    logic [2:0] o_right_offset;
    logic [3:0] o_char_size;
    logic [8:0] o_char_rgb_depth;
    logic [8:0] o_bk_rgb_depth;
    logic       o_flash_clk;

    modport master (
        output i_btn_up, i_btn_down, i_btn_left, i_btn_right,
               i_btn_size_up, i_btn_size_dn, i_btn_color, i_frame_start,
        input  o_up_offset, o_down_offset, o_left_offset, o_right_offset,
               o_char_size, o_char_rgb_depth, o_bk_rgb_depth, o_flash_clk
    );

    modport slave (
        input  i_btn_up, i_btn_down, i_btn_left, i_btn_right,
               i_btn_size_up, i_btn_size_dn, i_btn_color, i_frame_start,
        output o_up_offset, o_down_offset, o_left_offset, o_right_offset,
               o_char_size, o_char_rgb_depth, o_bk_rgb_depth, o_flash_clk
    );
endinterface

// File: rtl/disp_user_ctrl.sv
// Debounces user buttons and holds display settings, committing changes only on frame start.
// Optional DISP_BK_INVERT_EN: background colour follows the inverse of the foreground colour.
module disp_user_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FLASH_DIV       = 12500000,
    parameter int UP_MAX          = 479,
    parameter int SIZE_MIN        = 1,
    parameter int SIZE_MAX        = 8
) (
    input logic            i_clock,
    input logic            i_reset,
    disp_user_ctrl_if.slave ctrl
);
    localparam int NB   = 7;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FL_W = $clog2(FLASH_DIV + 1);
    localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3, B_SU = 4, B_SD = 5, B_CL = 6;

    function automatic logic [8:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 9'o777;
            3'd1:    palette = 9'o700;
            3'd2:    palette = 9'o070;
            3'd3:    palette = 9'o007;
            3'd4:    palette = 9'o770;
            3'd5:    palette = 9'o077;
            3'd6:    palette = 9'o707;
            default: palette = 9'o444;
        endcase
    endfunction

    logic [NB-1:0]   w_btn_raw;
    logic [NB-1:0]   r_sync1, r_sync2, r_deb, r_deb_d, r_pend;
    logic [DB_W-1:0] r_db_cnt [NB];
    logic [NB-1:0]   w_press, w_act;

    logic [9:0]      r_up;
    logic [2:0]      r_left;
    logic [3:0]      r_size;
    logic [2:0]      r_idx;
    logic [8:0]      r_char;
    logic [FL_W-1:0] r_flash_cnt;
    logic            r_flash;

    assign w_btn_raw = {ctrl.i_btn_color, ctrl.i_btn_size_dn, ctrl.i_btn_size_up,
                        ctrl.i_btn_right, ctrl.i_btn_left, ctrl.i_btn_down, ctrl.i_btn_up};
    assign w_press   = r_deb & ~r_deb_d;
    assign w_act     = r_pend | w_press;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press landing in the frame-start cycle is folded straight into w_act, so it is never lost.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pend <= '0;
        end else if (ctrl.i_frame_start) begin
            r_pend <= '0;
        end else begin
            r_pend <= r_pend | w_press;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_up   <= '0;
            r_left <= '0;
            r_size <= 4'(SIZE_MIN);
            r_idx  <= '0;
            r_char <= 9'o777;
        end else if (ctrl.i_frame_start) begin
            if (w_act[B_UP] && !w_act[B_DN]) begin
                if (r_up != '0) r_up <= r_up - 10'd1;
            end else if (w_act[B_DN] && !w_act[B_UP]) begin
                if (r_up != 10'(UP_MAX)) r_up <= r_up + 10'd1;
            end
            if (w_act[B_LT] && !w_act[B_RT]) r_left <= r_left - 3'd1;
            else if (w_act[B_RT] && !w_act[B_LT]) r_left <= r_left + 3'd1;
            if (w_act[B_SU] && !w_act[B_SD]) begin
                if (r_size != 4'(SIZE_MAX)) r_size <= r_size + 4'd1;
            end else if (w_act[B_SD] && !w_act[B_SU]) begin
                if (r_size != 4'(SIZE_MIN)) r_size <= r_size - 4'd1;
            end
            if (w_act[B_CL]) begin
                r_idx  <= r_idx + 3'd1;
                r_char <= palette(r_idx + 3'd1);
            end
        end
    end

`ifdef DISP_BK_INVERT_EN
    logic [8:0] r_bk;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bk <= 9'o000;
        end else if (ctrl.i_frame_start && w_act[B_CL]) begin
            r_bk <= ~palette(r_idx + 3'd1);
        end
    end
    assign ctrl.o_bk_rgb_depth = r_bk;
`else
    assign ctrl.o_bk_rgb_depth = 9'o000;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
        end else if (r_flash_cnt == FL_W'(FLASH_DIV - 1)) begin
            r_flash_cnt <= '0;
            r_flash     <= ~r_flash;
        end else begin
            r_flash_cnt <= r_flash_cnt + 1'b1;
        end
    end

    assign ctrl.o_up_offset      = r_up;
    assign ctrl.o_down_offset    = ~r_up[2:0];
    assign ctrl.o_left_offset    = r_left;
    assign ctrl.o_right_offset   = ~r_left;
    assign ctrl.o_char_size      = r_size;
    assign ctrl.o_char_rgb_depth = r_char;
    assign ctrl.o_flash_clk      = r_flash;
endmodule

// File: tb/tb_disp_user_ctrl.sv
// Scoreboard bench for disp_user_ctrl with short debounce and flash periods.
// Expected settings are pushed when a frame start is driven and popped one cycle later.
module tb_disp_user_ctrl;
    localparam int DB = 4;
    localparam int FD = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] btn   = '0;

    always #5 clock = ~clock;

    disp_user_ctrl_if u_if ();

    assign u_if.i_btn_up      = btn[0];
    assign u_if.i_btn_down    = btn[1];
    assign u_if.i_btn_left    = btn[2];
    assign u_if.i_btn_right   = btn[3];
    assign u_if.i_btn_size_up = btn[4];
    assign u_if.i_btn_size_dn = btn[5];
    assign u_if.i_btn_color   = btn[6];

    disp_user_ctrl #(.DEBOUNCE_CYCLES(DB), .FLASH_DIV(FD)) u_dut (
        .i_clock (clock),
        .i_reset (reset),
        .ctrl    (u_if)
    );

    typedef struct {
        int         up;
        int         left;
        int         size;
        logic [8:0] chr;
        logic [8:0] bk;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] pal_tab [8] = '{9'o777, 9'o700, 9'o070, 9'o007, 9'o770, 9'o077, 9'o707, 9'o444};
    int         m_up, m_left, m_size, m_idx;
    logic [6:0] m_pend;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_bk(input int idx);
`ifdef DISP_BK_INVERT_EN
        return ~pal_tab[idx];
`else
        return 9'o000;
`endif
    endfunction

    task automatic model_reset();
        m_up = 0; m_left = 0; m_size = 1; m_idx = 0; m_pend = '0;
    endtask

    task automatic push_current();
        exp_t e;
        e.up = m_up; e.left = m_left; e.size = m_size;
        e.chr = pal_tab[m_idx]; e.bk = exp_bk(m_idx);
        exp_q.push_back(e);
    endtask

    task automatic model_frame(input logic [6:0] act);
        if (act[0] && !act[1]) begin
            if (m_up > 0) m_up--;
        end else if (act[1] && !act[0]) begin
            if (m_up < 479) m_up++;
        end
        if (act[2] && !act[3]) m_left = (m_left + 7) % 8;
        else if (act[3] && !act[2]) m_left = (m_left + 1) % 8;
        if (act[4] && !act[5]) begin
            if (m_size < 8) m_size++;
        end else if (act[5] && !act[4]) begin
            if (m_size > 1) m_size--;
        end
        if (act[6]) m_idx = (m_idx + 1) % 8;
        push_current();
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_up"},    32'(u_if.o_up_offset),      32'(e.up));
        chk({tag, "_down"},  32'(u_if.o_down_offset),    32'((~e.up) & 7));
        chk({tag, "_left"},  32'(u_if.o_left_offset),    32'(e.left));
        chk({tag, "_right"}, 32'(u_if.o_right_offset),   32'((~e.left) & 7));
        chk({tag, "_size"},  32'(u_if.o_char_size),      32'(e.size));
        chk({tag, "_char"},  32'(u_if.o_char_rgb_depth), 32'(e.chr));
        chk({tag, "_bk"},    32'(u_if.o_bk_rgb_depth),   32'(e.bk));
    endtask

    task automatic check_now(input string tag);
        push_current();
        compare_pop(tag);
    endtask

    // Called on a negedge; extra carries presses whose pulse coincides with this frame start.
    task automatic frame(input string tag, input logic [6:0] extra);
        u_if.i_frame_start = 1'b1;
        model_frame(m_pend | extra);
        m_pend = '0;
        @(negedge clock);
        u_if.i_frame_start = 1'b0;
        compare_pop(tag);
    endtask

    task automatic press(input int b);
        @(negedge clock);
        btn[b] = 1'b1;
        m_pend[b] = 1'b1;
        repeat (8) @(negedge clock);
        btn[b] = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        model_reset();
        @(negedge clock);
        check_now("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        u_if.i_frame_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_now("reset");
        chk("reset_flash", 32'(u_if.o_flash_clk), 32'd0);
        reset = 1'b0;

        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            chk($sformatf("flash_c%0d", c), 32'(u_if.o_flash_clk), 32'((c / 5) % 2));
        end

        pulse_reset();
        repeat (7) @(negedge clock);
        chk("flash_pre_rst", 32'(u_if.o_flash_clk), 32'd1);
        #1 reset = 1'b1;
        #1 chk("flash_async_rst", 32'(u_if.o_flash_clk), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            chk($sformatf("flash_rs_c%0d", c), 32'(u_if.o_flash_clk), 32'((c / 5) % 2));
        end

        @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            btn[1] = (k % 2 == 0);
            repeat (2) @(negedge clock);
        end
        btn[1] = 1'b1;
        repeat (10) @(negedge clock);
        btn[1] = 1'b0;
        repeat (8) @(negedge clock);
        m_pend[1] = 1'b1;
        frame("bounce", '0);
        frame("bounce_idle", '0);

        for (int k = 0; k < 4; k++) begin
            press(0);
            frame("up_sat", '0);
        end
        for (int k = 0; k < 3; k++) begin
            press(5);
            frame("size_min", '0);
        end

        press(2);
        frame("left_wrap", '0);
        for (int k = 0; k < 8; k++) begin
            press(6);
            frame("color", '0);
        end

        press(3);
        repeat (100) @(negedge clock);
        check_now("deferred_hold");
        frame("deferred", '0);

        @(negedge clock);
        btn[4] = 1'b1;
        repeat (6) @(negedge clock);
        frame("same_cycle", 7'b0010000);
        btn[4] = 1'b0;
        repeat (8) @(negedge clock);
        frame("same_cycle_idle", '0);

        press(0); press(1);
        frame("up_down", '0);
        press(2); press(3);
        frame("left_right", '0);
        press(4); press(5);
        frame("size_both", '0);
        press(1); press(1);
        frame("double", '0);
        press(6);
        frame("color_one", '0);

        for (int k = 0; k < 9; k++) begin
            press(4);
            frame("size_max", '0);
        end

        press(6);
        pulse_reset();
        frame("rst_lost", '0);

        for (int k = 0; k < 481; k++) begin
            press(1);
            frame("up_max", '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
